// File: rtl/mux_rr_arbiter_pkg.sv
// Shared encodings for the two-requester round-robin mux arbiter.
package mux_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } arb_state_e;

    // Identity of the most recently granted requester.
    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/mux_rr_arbiter_mux2.sv
// Purely combinational WIDTH-bit 2:1 mux; sel=0 picks a, sel=1 picks b.
module mux2_w #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit 2:1 mux between requesters A and B,
// with a hold limit so neither side can starve the other, and a registered output.
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             sel,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    arb_state_e       state_q, state_d;
    logic             last_q, last_d;
    logic [7:0]       hold_q, hold_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             vld_q;
    logic [WIDTH-1:0] mux_y;
    logic             other_req;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        hold_d    = hold_q;
        other_req = 1'b0;

        unique case (state_q)
            IDLE: begin
                // On a tie, the requester that was not granted last wins.
                if (req_a && (!req_b || last_q == REQ_B))
                    state_d = GRANT_A;
                else if (req_b)
                    state_d = GRANT_B;
            end
            GRANT_A: begin
                other_req = req_b;
                if (!req_a)
                    state_d = req_b ? GRANT_B : IDLE;
                else if (req_b && hold_q == HOLD_LAST)
                    state_d = GRANT_B;
            end
            GRANT_B: begin
                other_req = req_a;
                if (!req_b)
                    state_d = req_a ? GRANT_A : IDLE;
                else if (req_a && hold_q == HOLD_LAST)
                    state_d = GRANT_A;
            end
            default: state_d = IDLE;
        endcase

        // Count only contested cycles; saturate rather than wrap.
        if (state_d != state_q) begin
            hold_d = '0;
            if (state_d == GRANT_A) last_d = REQ_A;
            if (state_d == GRANT_B) last_d = REQ_B;
        end else if (other_req && hold_q != 8'hFF) begin
            hold_d = hold_q + 8'd1;
        end
    end

    mux2_w #(.WIDTH(WIDTH)) u_mux (
        .a   (a),
        .b   (b),
        .sel (gnt_b),
        .y   (mux_y)
    );

    assign out_d = (state_q != IDLE) ? mux_y : out_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= REQ_B;
            hold_q  <= '0;
            out_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            out_q   <= out_d;
            vld_q   <= (state_q != IDLE);
        end
    end

    assign gnt_a     = (state_q == GRANT_A);
    assign gnt_b     = (state_q == GRANT_B);
    assign sel       = gnt_b;
    assign out       = out_q;
    assign out_valid = vld_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against an owner/turn model.
module tb_mux_rr_arbiter;

    localparam int W  = 8;
    localparam int MH = 4;

    logic         clk = 1'b0;
    logic         rst, req_a, req_b;
    logic [W-1:0] a, b;
    logic         gnt_a, gnt_b, sel, out_valid;
    logic [W-1:0] out;

    int checks = 0;
    int errors = 0;

    // Model: who owns the mux (0 none, 1 A, 2 B), contested cycles so far,
    // who was granted most recently, and the registered output.
    int           m_own, m_cnt, m_last;
    logic [W-1:0] m_out;
    logic         m_vld;

    always #5 clk = ~clk;

    mux_rr_arbiter #(.WIDTH(W), .MAX_HOLD(MH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_a     (req_a),
        .req_b     (req_b),
        .a         (a),
        .b         (b),
        .gnt_a     (gnt_a),
        .gnt_b     (gnt_b),
        .sel       (sel),
        .out       (out),
        .out_valid (out_valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit ra, input bit rb,
                              input logic [W-1:0] av, input logic [W-1:0] bv);
        int  nxt;
        bit  mine, other;
        if (r) begin
            m_own = 0; m_cnt = 0; m_last = 2; m_out = '0; m_vld = 1'b0;
            return;
        end
        if (m_own != 0) m_out = (m_own == 2) ? bv : av;
        m_vld = (m_own != 0);
        nxt = m_own;
        mine  = (m_own == 1) ? ra : rb;
        other = (m_own == 1) ? rb : ra;
        if (m_own == 0) begin
            if (ra && rb)  nxt = (m_last == 1) ? 2 : 1;
            else if (ra)   nxt = 1;
            else if (rb)   nxt = 2;
        end else if (!mine) begin
            nxt = other ? 3 - m_own : 0;
        end else if (other && m_cnt == MH - 1) begin
            nxt = 3 - m_own;
        end
        if (nxt != m_own) begin
            m_cnt = 0;
            if (nxt != 0) m_last = nxt;
        end else if (m_own != 0 && other) begin
            m_cnt = m_cnt + 1;
        end
        m_own = nxt;
    endtask

    task automatic step(input bit r, input bit ra, input bit rb,
                        input logic [W-1:0] av, input logic [W-1:0] bv);
        rst = r; req_a = ra; req_b = rb; a = av; b = bv;
        @(posedge clk);
        model_edge(r, ra, rb, av, bv);
        #1;
        check("gnt_a", 32'(gnt_a), 32'(m_own == 1));
        check("gnt_b", 32'(gnt_b), 32'(m_own == 2));
        check("sel", 32'(sel), 32'(m_own == 2));
        check("out", 32'(out), 32'(m_out));
        check("out_valid", 32'(out_valid), 32'(m_vld));
        check("mutex", 32'(gnt_a & gnt_b), 32'd0);
    endtask

    initial begin
        m_own = 0; m_cnt = 0; m_last = 2; m_out = '0; m_vld = 1'b0;
        rst = 1'b1; req_a = 1'b0; req_b = 1'b0; a = '0; b = '0;

        // Reset, then idle.
        step(1, 0, 0, 8'h11, 8'h22);
        step(1, 0, 0, 8'h11, 8'h22);
        check("rst_out", 32'(out), 32'd0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 8'($urandom), 8'($urandom));
        check("idle_valid", 32'(out_valid), 32'd0);

        // Single requester A.
        step(0, 1, 0, 8'h3C, 8'h00);
        check("a_gnt_latency", 32'(gnt_a), 32'd1);
        step(0, 1, 0, 8'h3C, 8'h00);
        check("a_data", 32'(out), 32'h3C);
        step(0, 0, 0, 8'h00, 8'h00);
        check("a_release", 32'(gnt_a), 32'd0);
        step(0, 0, 0, 8'h00, 8'h00);
        check("a_valid_drop", 32'(out_valid), 32'd0);

        // Tie after reset: A first, then 4/4 alternation.
        step(1, 0, 0, 8'h00, 8'h00);
        for (int i = 1; i <= 12; i++) begin
            step(0, 1, 1, 8'(8'hA0 + i), 8'(8'hB0 + i));
            if (i == 1) check("tie_first_a", 32'(gnt_a), 32'd1);
            if (i == 4) check("tie_a_hold4", 32'(gnt_a), 32'd1);
            if (i == 5) check("tie_preempt_b", 32'(gnt_b), 32'd1);
            if (i == 9) check("tie_back_a", 32'(gnt_a), 32'd1);
        end

        // Uncontested hold, then B arrives and waits MAX_HOLD cycles.
        step(0, 0, 0, 8'h00, 8'h00);
        step(0, 1, 0, 8'h55, 8'h66);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 8'h55, 8'h66);
        check("no_preempt", 32'(gnt_a), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            step(0, 1, 1, 8'h55, 8'h66);
            if (i == 3) check("b_waits", 32'(gnt_b), 32'd0);
        end
        check("b_after_4", 32'(gnt_b), 32'd1);

        // Direct handoff B -> A with no idle bubble, then A -> B.
        step(0, 1, 0, 8'h77, 8'h88);
        check("handoff_to_a", 32'(gnt_a), 32'd1);
        step(0, 0, 1, 8'h77, 8'hA5);
        check("handoff_to_b", 32'(gnt_b), 32'd1);

        // Reset mid-grant in GRANT_B with out=A5.
        step(0, 0, 1, 8'h77, 8'hA5);
        check("gb_out_a5", 32'(out), 32'hA5);
        step(1, 1, 1, 8'h77, 8'hA5);
        check("rst_mid_gnt", 32'({gnt_a, gnt_b, sel, out_valid, out}), 32'd0);
        step(0, 1, 1, 8'h99, 8'hA5);
        check("rst_tie_a", 32'(gnt_a), 32'd1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 9) < 6, 8'($urandom), 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
